// File: rtl/ttl_event_scheduler.sv
// Timestamped event queue feeding a TTL_Controller: holds the head entry until the
// global timeline reaches its timestamp, then emits a one-cycle fire strobe.
module ttl_event_scheduler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              counter,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     clear_errors,
  input  logic                     wr_en,
  input  logic [63:0]              wr_timestamp,
  input  logic [63:0]              wr_value,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     armed,
  output logic                     counter_matched,
  output logic [127:0]             gpo_in,
  output logic                     overflow,
  output logic                     late_error,
  output logic [CNT_W-1:0]         late_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [63:0] ts;
    logic [63:0] value;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, FIRE} state_t;

  state_t          state_q, state_d;
  entry_t          mem [DEPTH];
  entry_t          hold;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_d;
  logic            push_ok, ovf_go;
  logic            load, fire_go, late_go;

  // Push side: a pop in the same cycle never makes room for the push.
  always_comb begin
    push_ok = wr_en && !full && !flush;
    ovf_go  = wr_en && full && !flush;
    count_d = fifo_count;
    if (flush) count_d = '0;
    else       count_d = fifo_count + CW'(push_ok) - CW'(load);
  end

  // Sequencer next-state; flush overrides every transition and action.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fire_go = 1'b0;
    late_go = 1'b0;
    unique case (state_q)
      IDLE:  if (enable && !empty) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = ARMED;
      end
      ARMED: begin
        if (enable) begin
          if (counter == hold.ts) begin
            fire_go = 1'b1;
            state_d = FIRE;
          end else if (counter > hold.ts) begin
            late_go = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FIRE:  state_d = (enable && !empty) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      load    = 1'b0;
      fire_go = 1'b0;
      late_go = 1'b0;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= entry_t'({wr_timestamp, wr_value});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wptr            <= '0;
      rptr            <= '0;
      fifo_count      <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      hold            <= '0;
      armed           <= 1'b0;
      counter_matched <= 1'b0;
      gpo_in          <= '0;
      overflow        <= 1'b0;
      late_error      <= 1'b0;
      late_count      <= '0;
    end else begin
      state_q    <= state_d;
      fifo_count <= count_d;
      full       <= (count_d == CW'(DEPTH));
      empty      <= (count_d == '0);

      if (flush)        wptr <= '0;
      else if (push_ok) wptr <= wptr + AW'(1);

      if (flush)     rptr <= '0;
      else if (load) rptr <= rptr + AW'(1);

      if (load) hold <= mem[rptr];

      armed           <= (state_d == ARMED);
      counter_matched <= fire_go;
      if (fire_go) gpo_in <= hold;

      // A new error in the same cycle as clear_errors takes precedence.
      overflow   <= ovf_go  || (overflow   && !clear_errors);
      late_error <= late_go || (late_error && !clear_errors);
      if (late_go) begin
        if (clear_errors)                         late_count <= CNT_W'(1);
        else if (late_count != {CNT_W{1'b1}})     late_count <= late_count + CNT_W'(1);
      end else if (clear_errors) begin
        late_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ttl_event_scheduler.sv
// Scoreboard bench for ttl_event_scheduler: expected fires are queued at push time
// and checked against every counter_matched strobe.
module tb_ttl_event_scheduler;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [63:0] ts;
    logic [63:0] value;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [63:0]            counter;
  logic                   enable, flush, clear_errors, wr_en;
  logic [63:0]            wr_timestamp, wr_value;
  logic                   full, empty, armed, counter_matched, overflow, late_error;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [127:0]           gpo_in;
  logic [CNT_W-1:0]       late_count;

  logic running;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];

  ttl_event_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .counter(counter), .enable(enable), .flush(flush),
    .clear_errors(clear_errors), .wr_en(wr_en), .wr_timestamp(wr_timestamp),
    .wr_value(wr_value), .full(full), .empty(empty), .fifo_count(fifo_count),
    .armed(armed), .counter_matched(counter_matched), .gpo_in(gpo_in),
    .overflow(overflow), .late_error(late_error), .late_count(late_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (counter=%0d)", tag, got, exp, counter);
    end
  endtask

  // Inputs change just after the rising edge; the timeline advances once per cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (running) counter = counter + 64'd1;
  endtask

  task automatic run_until(input logic [63:0] t);
    while (counter < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; clear_errors = 1'b0; wr_en = 1'b0;
    wr_timestamp = '0; wr_value = '0; running = 1'b0; counter = '0;
    step(); step();
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic push(input logic [63:0] ts, input logic [63:0] val, input bit fires);
    wr_en = 1'b1; wr_timestamp = ts; wr_value = val;
    if (fires) sbq.push_back('{ts: ts, value: val});
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1; step(); clear_errors = 1'b0;
  endtask

  // Every strobe must match the oldest expected fire, one tick after its timestamp.
  always @(negedge clk) begin
    if (!reset && counter_matched) begin
      if (sbq.size() == 0) begin
        check("spurious_fire", 128'(counter_matched), 128'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("fire_time", 128'(counter), 128'(e.ts + 64'd1));
        check("gpo_ts", 128'(gpo_in[127:64]), 128'(e.ts));
        check("gpo_val", 128'(gpo_in[63:0]), 128'(e.value));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state and two in-order fires
    do_reset();
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_full", 128'(full), 128'(0));
    check("rst_count", 128'(fifo_count), 128'(0));
    check("rst_armed", 128'(armed), 128'(0));
    check("rst_strobe", 128'(counter_matched), 128'(0));
    check("rst_gpo", gpo_in, 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_late", 128'(late_error), 128'(0));
    check("rst_latecnt", 128'(late_count), 128'(0));
    push(64'd100, 64'd1, 1'b1);
    push(64'd200, 64'd0, 1'b1);
    check("t1_count", 128'(fifo_count), 128'(2));
    enable = 1'b1; running = 1'b1;
    run_until(64'd210);
    check("t1_drain", 128'(sbq.size()), 128'(0));
    check("t1_gpo_hold", gpo_in, {64'd200, 64'd0});
    check("t1_latecnt", 128'(late_count), 128'(0));

    // Past timestamp dropped; the following entry still fires
    do_reset();
    counter = 64'd50;
    push(64'd5, 64'd1, 1'b0);
    push(64'd60, 64'd1, 1'b1);
    enable = 1'b1; running = 1'b1;
    run_until(64'd70);
    check("t2_late", 128'(late_error), 128'(1));
    check("t2_latecnt", 128'(late_count), 128'(1));
    check("t2_drain", 128'(sbq.size()), 128'(0));

    // Minimum spacing: one tick apart is late, three ticks apart both fire
    do_reset();
    push(64'd100, 64'd1, 1'b1);
    push(64'd101, 64'd0, 1'b0);
    enable = 1'b1; running = 1'b1;
    run_until(64'd120);
    check("t3a_latecnt", 128'(late_count), 128'(1));
    check("t3a_drain", 128'(sbq.size()), 128'(0));
    pulse_clear();
    check("t3a_clr_late", 128'(late_error), 128'(0));
    check("t3a_clr_cnt", 128'(late_count), 128'(0));
    do_reset();
    push(64'd100, 64'd1, 1'b1);
    push(64'd103, 64'd0, 1'b1);
    enable = 1'b1; running = 1'b1;
    run_until(64'd120);
    check("t3b_latecnt", 128'(late_count), 128'(0));
    check("t3b_drain", 128'(sbq.size()), 128'(0));

    // Overflow with enable low, then error clear and flush
    do_reset();
    for (int i = 0; i <= int'(DEPTH); i++) push(64'd1000 + 64'(i), 64'(i), 1'b0);
    check("t4_full", 128'(full), 128'(1));
    check("t4_count", 128'(fifo_count), 128'(DEPTH));
    check("t4_ovf", 128'(overflow), 128'(1));
    pulse_clear();
    check("t4_ovf_clr", 128'(overflow), 128'(0));
    check("t4_full_kept", 128'(full), 128'(1));
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_flush_empty", 128'(empty), 128'(1));
    check("t4_flush_count", 128'(fifo_count), 128'(0));

    // Flush of an armed entry, and flush coincident with a push
    do_reset();
    push(64'd300, 64'd1, 1'b0);
    enable = 1'b1; running = 1'b1;
    run_until(64'd250);
    check("t5_armed", 128'(armed), 128'(1));
    flush = 1'b1; step(); flush = 1'b0;
    check("t5_armed_clr", 128'(armed), 128'(0));
    check("t5_empty", 128'(empty), 128'(1));
    run_until(64'd310);
    flush = 1'b1; wr_en = 1'b1; wr_timestamp = 64'd400; wr_value = 64'd1;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("t5_fw_empty", 128'(empty), 128'(1));
    check("t5_fw_count", 128'(fifo_count), 128'(0));

    // Freeze while armed, late on re-enable, then reset while armed
    do_reset();
    push(64'd100, 64'd1, 1'b0);
    enable = 1'b1; running = 1'b1;
    run_until(64'd90);
    enable = 1'b0;
    run_until(64'd120);
    check("t6_frozen_armed", 128'(armed), 128'(1));
    check("t6_frozen_late", 128'(late_error), 128'(0));
    enable = 1'b1;
    step(); step();
    check("t6_late", 128'(late_error), 128'(1));
    check("t6_latecnt", 128'(late_count), 128'(1));
    check("t6_disarmed", 128'(armed), 128'(0));
    push(64'd500, 64'd1, 1'b0);
    run_until(64'd140);
    check("t6_armed2", 128'(armed), 128'(1));
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_armed", 128'(armed), 128'(0));
    check("t6_rst_empty", 128'(empty), 128'(1));
    check("t6_rst_latecnt", 128'(late_count), 128'(0));
    check("t6_rst_gpo", gpo_in, 128'(0));
    run_until(64'd510);
    check("t6_no_fire", 128'(counter_matched), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ttl_event_scheduler.md
Name: ttl_event_scheduler

Overview:
- Timestamped event queue and sequencer placed in front of one TTL_Controller instance.
- Host side pushes (timestamp, value) entries. The block holds the head entry until the global timeline counter reaches its timestamp, then drives the controller's gpo_in / counter_matched pair for exactly one cycle.
- Flags late entries and queue overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of late_count saturating counter.

Ports:
- clk  input  1  system clock, shared with TTL_Controller
- reset  input  1  synchronous, active-high
- counter  input  64  global timeline; increments by 1 per clk when running
- enable  input  1  1 = scheduler may arm/fire; 0 = freeze
- flush  input  1  one-cycle pulse: discard queue and armed entry
- clear_errors  input  1  one-cycle pulse: clear overflow, late_error, late_count
- wr_en  input  1  push request
- wr_timestamp  input  64  event time
- wr_value  input  64  event payload; bit 0 is TTL level
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- fifo_count  output  $clog2(DEPTH)+1  entries stored, excluding armed entry
- armed  output  1  an entry is held awaiting its time
- counter_matched  output  1  one-cycle fire strobe to TTL_Controller
- gpo_in  output  128  {timestamp[63:0], value[63:0]} of fired entry
- overflow  output  1  sticky: push attempted while full
- late_error  output  1  sticky: entry dropped because its time had passed
- late_count  output  CNT_W  dropped-entry count, saturating at all-ones

Behaviour:
- Reset (sync, active-high): FIFO pointers and count = 0, FSM = IDLE. All outputs 0, except empty = 1. Reset mid-operation discards everything; no fire strobe in the following cycle.
- Push: accepted when wr_en=1 and full=0. Written at the tail on the clock edge; fifo_count reflects it next cycle.
  - wr_en=1 while full=1: entry dropped, overflow set.
  - A pop in the same cycle does not free space for that push.
  - Simultaneous push and pop when not full: count unchanged.
- FSM states:
  - IDLE: if enable=1 and empty=0, go to LOAD.
  - LOAD: pop head into hold registers; armed=1 from next cycle; go to ARMED.
  - ARMED, enable=1:
    - counter == hold_ts: go to FIRE.
    - counter > hold_ts (unsigned): drop entry, set late_error, increment late_count (saturating), go to IDLE.
    - Otherwise stay in ARMED.
  - ARMED, enable=0: stay; no comparison, no late check.
  - FIRE: counter_matched=1 for this single cycle; gpo_in = {hold_ts, hold_value}; armed=0. Next state is LOAD if enable=1 and empty=0, else IDLE.
- gpo_in holds its last fired value between fires. Value is 0 after reset.
- Latency: counter_matched asserts in the cycle after the cycle in which counter == timestamp.
- Minimum spacing for back-to-back firing is 3 counter ticks (FIRE → LOAD → ARMED compare). Closer entries are reported late and dropped.
- Entries pushed with a timestamp already passed are dropped as late at their ARMED compare.
- enable=0 in IDLE: no LOAD. enable=0 in LOAD or FIRE: that state completes, then the block waits in ARMED or IDLE respectively.
- flush: highest priority after reset. Clears FIFO and armed, FSM to IDLE, suppresses any fire that cycle. A concurrent wr_en is ignored. Sticky flags and late_count are unaffected.
- clear_errors: clears overflow, late_error and late_count. If a new error occurs in the same cycle, the error wins (flag set, count = 1).
- Comparisons are unsigned 64-bit; counter wrap is not supported.

Test Plan:
- Push ts=100 (val 1) and ts=200 (val 0), enable=1, counter running from 0 → counter_matched high exactly at counter=101 and 201; gpo_in[63:0] = 1 then 0; gpo_in[127:64] = 100 then 200.
- Push ts=5 while counter=50 → no strobe; late_error=1, late_count=1; a queued ts=60 still fires at counter=61.
- Push ts=100 and ts=101 → first fires at 101; second is dropped as late, late_count=1. Same with ts=100 and ts=103 → both fire, at 101 and 104.
- Push DEPTH+1 entries with enable=0 → full=1, fifo_count=DEPTH, overflow=1. clear_errors → overflow=0, full unchanged.
- Arm ts=300, pulse flush at counter=250 → armed=0, empty=1, no strobe at 301. Flush coincident with wr_en → entry not stored.
- Armed ts=100, enable=0 from counter=90 to 120 → no fire. Re-enable at 120 → entry dropped as late. Reset asserted while armed → all outputs 0 next cycle, no strobe afterwards.
